// File: rtl/mux_scan_seq.sv
// mux_scan_seq: select-line sequencer for a downstream 4:1 mux.
// Walks the enabled channels (sel1 = ch[0], sel2 = ch[1]). Each channel is
// settled, strobed for one cycle, then held for a programmable dwell.
// The scan is either a single pass or a continuous loop until stopped.
// Build option: MUX_SCAN_MASK_EN -- when defined the channel mask is honoured
// and an all-zero mask at start raises err; otherwise all four channels scan.
module mux_scan_seq #(
  parameter int SETTLE_CYC = 2,
  parameter int DW_W       = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            cont_i,
  input  logic [3:0]      mask_i,
  input  logic [DW_W-1:0] dwell_i,
  output logic            sel1_o,
  output logic            sel2_o,
  output logic [1:0]      ch_id_o,
  output logic            sample_stb_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int SW    = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (DW_W > SW) ? DW_W : SW;

  typedef enum logic [1:0] {IDLE, SETTLE, STROBE, DWELL} state_t;

  typedef struct packed {
    logic            cont;
    logic [3:0]      mask;
    logic [DW_W-1:0] dwell;
  } cfg_t;

  typedef struct packed {
    logic       found;
    logic [1:0] ch;
  } pick_t;

  // Lowest set bit of m.
  function automatic pick_t pick_lowest(input logic [3:0] m);
    pick_t r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) begin
        r.found = 1'b1;
        r.ch    = 2'(i);
      end
    end
    return r;
  endfunction

  // Lowest set bit of m strictly above channel c.
  function automatic pick_t pick_above(input logic [3:0] m, input logic [1:0] c);
    pick_t r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (2'(i) > c)) begin
        r.found = 1'b1;
        r.ch    = 2'(i);
      end
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [1:0]       ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             err_d;
  logic             stb_q, busy_q, done_q, err_q;

  logic [3:0]       mask_eff;
  logic             stop_eff;
  logic [CNT_W-1:0] dwell_ext;
  pick_t            first_pick, next_pick, wrap_pick;

`ifdef MUX_SCAN_MASK_EN
  assign mask_eff = mask_i;
`else
  // Mask input is present but overridden: every channel is enabled.
  assign mask_eff = mask_i | 4'hF;
`endif

  // A stop seen in the same cycle as the advance decision still counts.
  assign stop_eff   = stop_q | stop_i;
  assign dwell_ext  = CNT_W'(cfg_q.dwell);
  assign first_pick = pick_lowest(mask_eff);
  assign next_pick  = pick_above(cfg_q.mask, ch_q);
  assign wrap_pick  = pick_lowest(cfg_q.mask);

  // Next-state logic; ch only changes on the way into SETTLE.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start_i && !stop_i) begin
          if (first_pick.found) begin
            cfg_d   = '{cont: cont_i, mask: mask_eff, dwell: dwell_i};
            ch_d    = first_pick.ch;
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
`ifdef MUX_SCAN_MASK_EN
            err_d = 1'b1;
`endif
          end
        end
      end
      SETTLE: begin
        stop_d = stop_eff;
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE, DWELL: begin
        stop_d = stop_eff;
        if ((state_q == STROBE && cfg_q.dwell != '0) ||
            (state_q == DWELL && (cnt_q + CNT_W'(1)) != dwell_ext)) begin
          // Enter or continue the dwell hold.
          cnt_d   = (state_q == STROBE) ? '0 : cnt_q + CNT_W'(1);
          state_d = DWELL;
        end else begin
          // Advance to the next channel, wrap, or finish.
          cnt_d = '0;
          if (next_pick.found && !stop_eff) begin
            ch_d    = next_pick.ch;
            state_d = SETTLE;
          end else if (cfg_q.cont && !stop_eff) begin
            ch_d    = wrap_pick.ch;
            state_d = SETTLE;
          end else begin
            stop_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, config latch and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      stb_q   <= (state_d == STROBE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
      err_q   <= err_d;
    end
  end

  assign sel1_o       = ch_q[0];
  assign sel2_o       = ch_q[1];
  assign ch_id_o      = ch_q;
  assign sample_stb_o = stb_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq (SETTLE_CYC=2, DW_W=8).
// Cycle 0 is the cycle in which start is driven; outputs are sampled on
// the falling edge of each cycle and folded into per-cycle bit vectors.
module tb_mux_scan_seq;
  logic       clk = 1'b0;
  logic       rst, start, stop, cont;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic       sel1, sel2, stb, busy, done, err;
  logic [1:0] ch_id;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] stb_v, busy_v, done_v, err_v;
  logic [1:0]  ch_at [32];
  logic [1:0]  sel_at [32];
  logic [1:0]  ch_or;
  int          stb_at [8];
  int          stb_n, done_at;

  mux_scan_seq #(.SETTLE_CYC(2), .DW_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .cont_i(cont),
    .mask_i(mask), .dwell_i(dwell), .sel1_o(sel1), .sel2_o(sel2),
    .ch_id_o(ch_id), .sample_stb_o(stb), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Run ncyc cycles: start in cycle 0 (and start2), stop / rst pulsed in the given cycles.
  task automatic run(input logic [3:0] m, input logic c, input logic [7:0] dw,
                     input int stop_cyc, input int rst_cyc, input int start2, input int ncyc);
    stb_v = '0; busy_v = '0; done_v = '0; err_v = '0; ch_or = '0;
    stb_n = 0; done_at = -1;
    for (int k = 0; k < 32; k++) begin ch_at[k] = '0; sel_at[k] = '0; end
    for (int k = 0; k < 8; k++) stb_at[k] = -1;
    mask = m; cont = c; dwell = dw;
    @(posedge clk); #1;
    for (int k = 0; k < ncyc; k++) begin
      start = (k == 0) || (k == start2);
      stop  = (k == stop_cyc);
      rst   = (k == rst_cyc);
      @(negedge clk);
      if (k < 32) begin
        stb_v[k] = stb; busy_v[k] = busy; done_v[k] = done; err_v[k] = err;
        ch_at[k] = ch_id; sel_at[k] = {sel2, sel1};
      end
      ch_or = ch_or | ch_id;
      if (stb === 1'b1) begin
        if (stb_n < 8) stb_at[stb_n] = k;
        stb_n++;
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = 4'hF; dwell = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({sel2, sel1} !== 2'b00) begin n_bad++; $display("FAIL reset_sel got %b exp 00", {sel2, sel1}); end
    n_cmp++; if (ch_id !== 2'd0) begin n_bad++; $display("FAIL reset_ch got %0d exp 0", ch_id); end
    n_cmp++; if ({stb, busy, done, err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b exp 0000", {stb, busy, done, err}); end
    #1 rst = 1'b0;
  endtask

  task automatic test_full_scan();
    do_reset();
    run(4'b1111, 1'b0, 8'd0, -1, -1, -1, 20);
    n_cmp++; if (stb_v !== 32'h0000_1248) begin n_bad++; $display("FAIL full_stb got %h exp 00001248", stb_v); end
    n_cmp++; if (busy_v !== 32'h0000_1FFE) begin n_bad++; $display("FAIL full_busy got %h exp 00001ffe", busy_v); end
    n_cmp++; if (done_v !== 32'h0000_2000) begin n_bad++; $display("FAIL full_done got %h exp 00002000", done_v); end
    n_cmp++; if ({ch_at[3], ch_at[6], ch_at[9], ch_at[12]} !== 8'b00_01_10_11) begin n_bad++;
      $display("FAIL full_ch got %0d %0d %0d %0d exp 0 1 2 3", ch_at[3], ch_at[6], ch_at[9], ch_at[12]); end
    n_cmp++; if (sel_at[9] !== 2'b10) begin n_bad++; $display("FAIL full_sel9 got %b exp 10", sel_at[9]); end
  endtask

  task automatic test_mask_dwell();
    do_reset();
    run(4'b1010, 1'b0, 8'd2, -1, -1, -1, 24);
`ifdef MUX_SCAN_MASK_EN
    n_cmp++; if (stb_v !== 32'h0000_0108) begin n_bad++; $display("FAIL md_stb got %h exp 00000108", stb_v); end
    n_cmp++; if (done_v !== 32'h0000_0800) begin n_bad++; $display("FAIL md_done got %h exp 00000800", done_v); end
    n_cmp++; if (busy_v !== 32'h0000_07FE) begin n_bad++; $display("FAIL md_busy got %h exp 000007fe", busy_v); end
    n_cmp++; if ({sel_at[1], sel_at[5], sel_at[6], sel_at[11]} !== 8'b01_01_11_11) begin n_bad++;
      $display("FAIL md_sel got %b %b %b %b exp 01 01 11 11", sel_at[1], sel_at[5], sel_at[6], sel_at[11]); end
`else
    n_cmp++; if (stb_v !== 32'h0004_2108) begin n_bad++; $display("FAIL md_stb got %h exp 00042108", stb_v); end
    n_cmp++; if (done_v !== 32'h0020_0000) begin n_bad++; $display("FAIL md_done got %h exp 00200000", done_v); end
    n_cmp++; if (busy_v !== 32'h001F_FFFE) begin n_bad++; $display("FAIL md_busy got %h exp 001ffffe", busy_v); end
    n_cmp++; if ({ch_at[3], ch_at[8], ch_at[13], ch_at[18]} !== 8'b00_01_10_11) begin n_bad++;
      $display("FAIL md_ch got %0d %0d %0d %0d exp 0 1 2 3", ch_at[3], ch_at[8], ch_at[13], ch_at[18]); end
`endif
  endtask

  task automatic test_cont_stop();
    do_reset();
    run(4'b0001, 1'b1, 8'd0, 7, -1, -1, 20);
    n_cmp++; if (stb_v !== 32'h0000_0248) begin n_bad++; $display("FAIL cs_stb got %h exp 00000248", stb_v); end
    n_cmp++; if (done_v !== 32'h0000_0400) begin n_bad++; $display("FAIL cs_done got %h exp 00000400", done_v); end
    n_cmp++; if (busy_v !== 32'h0000_03FE) begin n_bad++; $display("FAIL cs_busy got %h exp 000003fe", busy_v); end
`ifdef MUX_SCAN_MASK_EN
    n_cmp++; if (ch_or !== 2'b00) begin n_bad++; $display("FAIL cs_sel_static got %b exp 00", ch_or); end
`else
    n_cmp++; if (ch_at[9] !== 2'd2) begin n_bad++; $display("FAIL cs_ch9 got %0d exp 2", ch_at[9]); end
`endif
  endtask

  task automatic test_zero_mask();
    do_reset();
    run(4'b0000, 1'b0, 8'd0, -1, -1, -1, 20);
`ifdef MUX_SCAN_MASK_EN
    n_cmp++; if (err_v !== 32'h0000_0002) begin n_bad++; $display("FAIL zm_err got %h exp 00000002", err_v); end
    n_cmp++; if (busy_v !== 32'h0) begin n_bad++; $display("FAIL zm_busy got %h exp 00000000", busy_v); end
    n_cmp++; if (stb_v !== 32'h0) begin n_bad++; $display("FAIL zm_stb got %h exp 00000000", stb_v); end
`else
    n_cmp++; if (err_v !== 32'h0) begin n_bad++; $display("FAIL zm_err got %h exp 00000000", err_v); end
    n_cmp++; if (stb_v !== 32'h0000_1248) begin n_bad++; $display("FAIL zm_stb got %h exp 00001248", stb_v); end
    n_cmp++; if (done_v !== 32'h0000_2000) begin n_bad++; $display("FAIL zm_done got %h exp 00002000", done_v); end
`endif
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    run(4'b1111, 1'b1, 8'd0, -1, 5, 2, 16);
    n_cmp++; if (stb_v !== 32'h0000_0008) begin n_bad++; $display("FAIL rm_stb got %h exp 00000008", stb_v); end
    n_cmp++; if (busy_v !== 32'h0000_003E) begin n_bad++; $display("FAIL rm_busy got %h exp 0000003e", busy_v); end
    n_cmp++; if (done_v !== 32'h0) begin n_bad++; $display("FAIL rm_done got %h exp 00000000", done_v); end
    n_cmp++; if ({ch_at[5], ch_at[6]} !== 4'b01_00) begin n_bad++;
      $display("FAIL rm_ch got %0d %0d exp 1 0", ch_at[5], ch_at[6]); end
  endtask

  task automatic test_start_stop_same();
    do_reset();
    run(4'b1111, 1'b0, 8'd0, 0, -1, -1, 12);
    n_cmp++; if ((busy_v | done_v | err_v | stb_v) !== 32'h0) begin n_bad++;
      $display("FAIL ss_full got busy %h done %h err %h stb %h exp all 0", busy_v, done_v, err_v, stb_v); end
    do_reset();
    run(4'b0000, 1'b0, 8'd0, 0, -1, -1, 12);
    n_cmp++; if ((busy_v | err_v) !== 32'h0) begin n_bad++;
      $display("FAIL ss_zero got busy %h err %h exp 0 0", busy_v, err_v); end
  endtask

  task automatic test_max_dwell();
    do_reset();
    run(4'b1111, 1'b0, 8'd255, -1, -1, -1, 1040);
    n_cmp++; if (stb_n !== 4) begin n_bad++; $display("FAIL mx_count got %0d exp 4", stb_n); end
    n_cmp++; if (stb_at[1] !== 261 || stb_at[3] !== 777) begin n_bad++;
      $display("FAIL mx_stb got %0d %0d exp 261 777", stb_at[1], stb_at[3]); end
    n_cmp++; if (done_at !== 1033) begin n_bad++; $display("FAIL mx_done got %0d exp 1033", done_at); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = 4'h0; dwell = 8'd0;
    test_reset();
    test_full_scan();
    test_mask_dwell();
    test_cont_stop();
    test_zero_mask();
    test_reset_mid_scan();
    test_start_stop_same();
    test_max_dwell();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
